// File: rtl/imm_encode.sv
// Immediate-load encoder: turns a 32-bit constant into one ADDI/LUI word or a LUI+ORI pair.
// Optional build macro IMMENC_STATS_EN adds saturating stat_words / stat_split counters.
module imm_encode #(
  parameter logic [5:0] OPC_ADDI = 6'h08,
  parameter logic [5:0] OPC_LUI  = 6'h0F,
  parameter logic [5:0] OPC_ORI  = 6'h0D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
`ifdef IMMENC_STATS_EN
  ,
  output logic [15:0] stat_words,
  output logic [15:0] stat_split
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

  state_t      state;
  logic        vld_p0;
  logic        last_p0;
  logic [31:0] instr_p0;
  logic [4:0]  rd_p0;
  logic [15:0] lo_p0;
  logic        in_hs;
  logic        out_hs;

  // Fits the sign-extended 16-bit immediate of ADDI.
  function automatic logic is_short(input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    return (sv >= -32'sd32768) && (sv <= 32'sd32767);
  endfunction

  function automatic logic is_split(input logic [31:0] v);
    return !is_short(v) && (v[15:0] != 16'h0000);
  endfunction

  function automatic logic [31:0] first_word(input logic [31:0] v, input logic [4:0] rd);
    if (is_short(v))
      return {OPC_ADDI, 5'd0, rd, v[15:0]};
    else
      return {OPC_LUI, 5'd0, rd, v[31:16]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign out_hs    = vld_p0 & out_ready;
  assign in_ready  = (state == IDLE) | (out_hs & last_p0);
  assign in_hs     = in_valid & in_ready;
  assign out_valid = vld_p0;
  assign out_instr = instr_p0;
  assign out_last  = last_p0;

  // Accept stage: a new constant always wins over retiring the previous last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      instr_p0 <= 32'h0;
    end else if (in_hs) begin
      state    <= EMIT;
      vld_p0   <= 1'b1;
      instr_p0 <= first_word(in_value, in_rd);
      last_p0  <= !is_split(in_value);
    end else if (out_hs) begin
      if (!last_p0) begin
        state    <= EMIT2;
        instr_p0 <= {OPC_ORI, rd_p0, rd_p0, lo_p0};
        last_p0  <= 1'b1;
      end else begin
        state    <= IDLE;
        vld_p0   <= 1'b0;
      end
    end
  end

  // Operands for the ORI word, captured once so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      rd_p0 <= in_rd;
      lo_p0 <= in_value[15:0];
    end
  end

`ifdef IMMENC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= 16'h0;
      stat_split <= 16'h0;
    end else begin
      if (out_hs)
        stat_words <= sat_inc16(stat_words);
      if (in_hs && is_split(in_value))
        stat_split <= sat_inc16(stat_split);
    end
  end
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: directed test-plan vectors plus randomized constants
// checked against a range-based reference model.
module tb_imm_encode;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_last;
`ifdef IMMENC_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_split;
`endif

  always #5 clk = ~clk;

  imm_encode dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_last(out_last)
`ifdef IMMENC_STATS_EN
    , .stat_words(stat_words), .stat_split(stat_split)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          rand_ready = 0;
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: classify by numeric range, not by bit patterns.
  task automatic push_model(input logic [31:0] v, input logic [4:0] rd);
    longint sv;
    int unsigned hi, lo;
    sv = longint'($signed(v));
    hi = v / 65536;
    lo = v % 65536;
    if (sv >= -32768 && sv <= 32767)
      exp_q.push_back({1'b1, 6'h08, 5'd0, rd, 16'(lo)});
    else if (lo == 0)
      exp_q.push_back({1'b1, 6'h0F, 5'd0, rd, 16'(hi)});
    else begin
      exp_q.push_back({1'b0, 6'h0F, 5'd0, rd, 16'(hi)});
      exp_q.push_back({1'b1, 6'h0D, rd, rd, 16'(lo)});
    end
  endtask

  // Presents one constant, returns after the accepting edge (+1). acc = cycle of acceptance.
  task automatic offer(input logic [31:0] v, input logic [4:0] rd, output int acc);
    int t;
    t = 0;
    acc = -1;
    in_valid = 1'b1;
    in_value = v;
    in_rd = rd;
    forever begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) break;
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: in_ready stuck 0, required 1 (value %h)", v);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    acc = cyc;
    #1;
    in_valid = 1'b0;
    chk("latency_out_valid", {32'h0, out_valid}, 33'h1);
  endtask

  // Monitor: pops on every output handshake and checks hold stability during stalls.
  initial begin
    bit          stalled;
    logic [32:0] held;
    logic [32:0] e;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
        continue;
      end
      if (stalled && out_valid)
        chk("stall_hold", {out_last, out_instr}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got %h last %b, required no word", out_instr, out_last);
        end else begin
          e = exp_q.pop_front();
          chk("word", {out_last, out_instr}, e);
        end
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = {out_last, out_instr};
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin
    int a0, a1, a2;
    int k;
    logic [31:0] r, v;

    // Reset state
    #12;
    chk("reset_out_valid", {32'h0, out_valid}, 33'h0);
    chk("reset_out_instr", {1'b0, out_instr}, 33'h0);
    chk("reset_out_last",  {32'h0, out_last}, 33'h0);
    chk("reset_in_ready",  {32'h0, in_ready}, 33'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SHORT positive / negative
    exp_q.push_back({1'b1, 32'h200300AD});
    offer(32'h000000AD, 5'd3, a0);
    chk("short_pos_now", {out_last, out_instr}, {1'b1, 32'h200300AD});
    exp_q.push_back({1'b1, 32'h2003FD72});
    offer(32'hFFFFFD72, 5'd3, a0);
    @(posedge clk); #1;

    // SPLIT with 3-cycle backpressure, followed by a pending SHORT offer
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h3C058908});
    exp_q.push_back({1'b1, 32'h34A51BA6});
    offer(32'h89081BA6, 5'd5, a0);
    in_valid = 1'b1; in_value = 32'h0000_1234; in_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {32'h0, in_ready}, 33'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("split_first_in_ready", {32'h0, in_ready}, 33'h0);
    @(posedge clk); #1;
    chk("split_second_now", {out_last, out_instr}, {1'b1, 32'h34A51BA6});
    chk("split_second_in_ready", {32'h0, in_ready}, 33'h1);
    exp_q.push_back({1'b1, 6'h08, 5'd0, 5'd9, 16'h1234});
    offer(32'h0000_1234, 5'd9, a0);

    // UPPER and sign boundary
    exp_q.push_back({1'b1, 32'h3C020001});
    offer(32'h00010000, 5'd2, a0);
    exp_q.push_back({1'b0, 32'h3C010000});
    exp_q.push_back({1'b1, 32'h34218000});
    offer(32'h00008000, 5'd1, a0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Back-to-back SHORT
    exp_q.push_back({1'b1, 32'h20040001});
    offer(32'h00000001, 5'd4, a0);
    exp_q.push_back({1'b1, 32'h2005FFFF});
    offer(32'hFFFFFFFF, 5'd5, a1);
    exp_q.push_back({1'b1, 32'h20007FFF});
    offer(32'h00007FFF, 5'd0, a2);
    chk("b2b_gap01", 33'(a1 - a0), 33'd1);
    chk("b2b_gap12", 33'(a2 - a1), 33'd1);
    @(posedge clk); #1;

    // Reset between the two SPLIT words
    exp_q.push_back({1'b0, 32'h3C071234});
    exp_q.push_back({1'b1, 32'h34E75678});
    offer(32'h12345678, 5'd7, a0);
    @(posedge clk); #1;
    chk("pre_reset_ori", {out_last, out_instr}, {1'b1, 32'h34E75678});
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", {32'h0, out_valid}, 33'h0);
    chk("mid_reset_in_ready", {32'h0, in_ready}, 33'h1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_out_valid", {32'h0, out_valid}, 33'h0);

    // Randomized traffic with random backpressure
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      k = $urandom_range(0, 2);
      if (k == 0)      v = {{16{r[15]}}, r[15:0]};
      else if (k == 1) v = {r[31:16], 16'h0000};
      else             v = $urandom;
      push_model(v, 5'($urandom_range(0, 31)));
      offer(v, exp_q[exp_q.size() - 1][20:16], a0);
    end
    rand_ready = 0;
    out_ready = 1'b1;

    // Drain
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", 33'(exp_q.size()), 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule

// File: doc/imm_encode.md
# imm_encode

Immediate-load encoder for the 32-bit processor: accepts a 32-bit constant and a destination register, and emits the one or two instruction words that rebuild that constant in the register. It is the inverse of the decode-side immediate extender, which sign-extends `instr[15:0]` for arithmetic immediates and zero-extends it for logical ones. It sits between the constant-generation front end (boot loader or test sequencer) and the instruction memory write port. Both sides use a valid/ready handshake.

## Interface
Parameters:
- `OPC_ADDI`, default 6'h08: opcode for the sign-extended add-immediate.
- `OPC_LUI`, default 6'h0F: opcode for load-upper-immediate.
- `OPC_ORI`, default 6'h0D: opcode for the zero-extended OR-immediate.

Instruction layout: `[31:26]` opcode, `[25:21]` rs, `[20:16]` rd, `[15:0]` imm.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: a constant is offered.
- `in_ready` out 1: the encoder accepts the offered constant this cycle.
- `in_value` in 32: constant to encode.
- `in_rd` in 5: destination register.
- `out_valid` out 1: `out_instr` holds a valid instruction word.
- `out_ready` in 1: the consumer takes the word this cycle.
- `out_instr` out 32: encoded instruction word.
- `out_last` out 1: this word is the final word of the current constant.

## Operation
- Classification, for `v = in_value`, `hi = v[31:16]`, `lo = v[15:0]`:
  - SHORT when `hi == {16{v[15]}}`. Emits one word: `{OPC_ADDI, 5'd0, rd, lo}`.
  - UPPER when not SHORT and `lo == 0`. Emits one word: `{OPC_LUI, 5'd0, rd, hi}`.
  - SPLIT otherwise. Emits two words: `{OPC_LUI, 5'd0, rd, hi}`, then `{OPC_ORI, rd, rd, lo}`.
- `out_last` is 1 on SHORT and UPPER words and on the second SPLIT word. It is 0 on the first SPLIT word.
- States:
  - IDLE: no output word pending.
  - EMIT: the single word, or the first word, is held on the output.
  - EMIT2: the second SPLIT word is held on the output.
- Transitions:
  - IDLE to EMIT on an input handshake.
  - EMIT to EMIT2 on an output handshake when the constant is SPLIT.
  - EMIT or EMIT2 to IDLE on an output handshake with `out_last = 1`, unless a new input handshake happens in the same cycle. In that case the next state is EMIT with the new constant.
- `in_ready = (state == IDLE) | (out_valid & out_ready & out_last)`. This allows one constant per cycle for SHORT and UPPER traffic.
- The captured value, rd and class are registered at input acceptance. Later changes on `in_*` do not affect words already in flight.
- `rd = 0` is encoded normally; no special case.
- While `out_valid = 1` and `out_ready = 0`, `out_instr` and `out_last` hold stable.

## Timing
- Reset values: `out_valid = 0`, `out_instr = 32'h0`, `out_last = 0`, `in_ready = 1` (IDLE).
- Latency: an input accepted at edge N presents its first word from edge N (registered output, visible during cycle N+1).
- A SPLIT second word appears on the edge after the first word's handshake. The earliest spacing between the two words is one cycle.
- Reset asserted mid-sequence, including between the two SPLIT words, clears the state immediately. Any pending word is discarded and is not re-emitted after release.
- `in_valid` held high while `in_ready = 0` is not accepted and causes no state change.

## Configuration
- `IMMENC_STATS_EN`
  - Defined: adds output ports `stat_words` (16 bits) and `stat_split` (16 bits).
    - `stat_words` increments on every output handshake.
    - `stat_split` increments on every accepted SPLIT constant.
    - Both saturate at 16'hFFFF and reset to 0 on `rst_n`.
  - Undefined: the ports and counters are absent. Core behaviour is identical.

## Test plan
- SHORT positive: `value = 32'h000000AD`, rd = 3, `out_ready = 1` -> one word `32'h200300AD`, last = 1, one cycle after acceptance.
- SHORT negative: `value = 32'hFFFFFD72`, rd = 3 -> one word `32'h2003FD72`, last = 1.
- SPLIT with backpressure: `value = 32'h89081BA6`, rd = 5, `out_ready` low for 3 cycles.
  - Required: `32'h3C058908` with last = 0, held stable during the stall.
  - Then `32'h34A51BA6` with last = 1.
  - `in_ready` stays 0 until the second handshake.
- UPPER and sign boundary:
  - `value = 32'h00010000`, rd = 2 -> `32'h3C020001`, last = 1.
  - `value = 32'h00008000`, rd = 1 -> `32'h3C010000`, then `32'h34218000`.
- Back-to-back and reset:
  - Three SHORT constants offered on consecutive cycles -> three words on consecutive cycles.
  - `rst_n` pulsed low between the two SPLIT words -> `out_valid = 0` immediately, and no ORI word after release.
